// File: rtl/pipe_hilo_writeback.sv
// HI/LO write-back stage: owns HI/LO, a multi-cycle multiply/restoring-divide engine,
// the EX/MEM write-back mux and the MEM/WB register. Everything freezes on waitrequest.
module pipe_hilo_writeback #(
    parameter int DATA_W      = 32,
    parameter int MUL_LAT     = 2,
    parameter int LINK_OFFSET = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              waitrequest,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              op_ready,
    output logic              hilo_busy,
    input  logic [2:0]        ex_mem_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] reg_pc,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wb_sel,
    output logic [DATA_W-1:0] ex_mem_result,
    output logic [DATA_W-1:0] mem_wb_result,
    output logic              stall_req
);
    localparam int CNT_W = $clog2((DATA_W > MUL_LAT ? DATA_W : MUL_LAT) + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi, r_lo, r_wb;
    logic [DATA_W-1:0]   r_a, r_b;
    logic                r_sgn;
    logic [DATA_W-1:0]   r_rem, r_quo, r_div;
    logic                r_neg_q, r_neg_r, r_dz;

    logic                w_accept, w_signed;
    logic [DATA_W-1:0]   w_abs_a, w_abs_b;
    logic [2*DATA_W-1:0] w_ext_a, w_ext_b, w_prod;
    logic [DATA_W:0]     w_shift, w_diff;
    logic [DATA_W-1:0]   w_q_fix, w_r_fix;

    assign op_ready  = (r_state == S_IDLE);
    assign hilo_busy = !op_ready;
    assign w_accept  = op_valid && op_ready && !waitrequest;
    assign w_signed  = !op_code[0];

    assign w_abs_a = (w_signed && op_a[DATA_W-1]) ? -op_a : op_a;
    assign w_abs_b = (w_signed && op_b[DATA_W-1]) ? -op_b : op_b;

    // Sign- or zero-extend the latched operands so one 2W multiply serves MULT and MULTU.
    assign w_ext_a = {{DATA_W{r_sgn & r_a[DATA_W-1]}}, r_a};
    assign w_ext_b = {{DATA_W{r_sgn & r_b[DATA_W-1]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Restoring step: quotient bits shift in from the bottom as dividend bits shift out the top.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_wb    <= '0;
        end else if (!waitrequest) begin
            r_wb <= ex_mem_result;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op_code)
                            3'b000, 3'b001: begin
                                r_state <= S_MUL;
                                r_cnt   <= CNT_W'(MUL_LAT);
                                r_a     <= op_a;
                                r_b     <= op_b;
                                r_sgn   <= w_signed;
                            end
                            3'b010, 3'b011: begin
                                r_state <= S_DIV;
                                r_cnt   <= CNT_W'(DATA_W);
                                r_a     <= op_a;
                                r_rem   <= '0;
                                r_quo   <= w_abs_a;
                                r_div   <= w_abs_b;
                                r_neg_q <= w_signed && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                                r_neg_r <= w_signed && op_a[DATA_W-1];
                                r_dz    <= (op_b == '0);
                            end
                            3'b100:  r_hi <= op_a;
                            3'b101:  r_lo <= op_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        {r_hi, r_lo} <= w_prod;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (!w_diff[DATA_W]) begin
                        r_rem <= w_diff[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                    end
                    if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
                    else                    r_cnt   <= r_cnt - CNT_W'(1);
                end
                default: begin
                    r_state <= S_IDLE;
                    if (r_dz) begin
                        r_lo <= '1;
                        r_hi <= r_a;
                    end else begin
                        r_lo <= w_q_fix;
                        r_hi <= w_r_fix;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ex_mem_result = '0;
        case (ex_mem_sel)
            3'b000:  ex_mem_result = alu_result;
            3'b010:  ex_mem_result = reg_pc + DATA_W'(LINK_OFFSET);
            3'b011:  ex_mem_result = r_hi;
            3'b100:  ex_mem_result = r_lo;
            default: ex_mem_result = '0;
        endcase
    end

    assign stall_req     = hilo_busy && (ex_mem_sel == 3'b011 || ex_mem_sel == 3'b100);
    assign mem_wb_result = mem_wb_sel ? mem_rdata : r_wb;

endmodule

// File: tb/tb_pipe_hilo_writeback.sv
// Bench for pipe_hilo_writeback: directed scenarios plus random HI/LO ops
// checked against an arithmetic reference model.
module tb_pipe_hilo_writeback;
    localparam int W = 32;
    localparam int MUL_LAT = 2;

    logic         clk = 0, reset = 0, waitrequest = 0, op_valid = 0, mem_wb_sel = 0;
    logic [2:0]   op_code = 0, ex_mem_sel = 0;
    logic [W-1:0] op_a = 0, op_b = 0, alu_result = 0, reg_pc = 0, mem_rdata = 0;
    logic         op_ready, hilo_busy, stall_req;
    logic [W-1:0] ex_mem_result, mem_wb_result;

    int checks = 0, errors = 0;
    logic [W-1:0] exp_hi = 0, exp_lo = 0;

    pipe_hilo_writeback #(.DATA_W(W), .MUL_LAT(MUL_LAT), .LINK_OFFSET(8)) dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest),
        .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready), .hilo_busy(hilo_busy),
        .ex_mem_sel(ex_mem_sel), .alu_result(alu_result), .reg_pc(reg_pc),
        .mem_rdata(mem_rdata), .mem_wb_sel(mem_wb_sel),
        .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: what HI/LO should hold after an op, from the instruction semantics.
    task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] p;
        int qa, qb;
        case (op)
            3'd0: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                p = 64'(sa * sb);
                exp_hi = p[63:32]; exp_lo = p[31:0];
            end
            3'd1: begin
                p = {32'b0, a} * {32'b0, b};
                exp_hi = p[63:32]; exp_lo = p[31:0];
            end
            3'd2: begin
                qa = $signed(a); qb = $signed(b);
                if (b == 0) begin exp_lo = '1; exp_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin exp_lo = a; exp_hi = 0; end
                else begin exp_lo = 32'(qa / qb); exp_hi = 32'(qa % qb); end
            end
            3'd3: begin
                if (b == 0) begin exp_lo = '1; exp_hi = a; end
                else begin exp_lo = a / b; exp_hi = a % b; end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input logic [2:0] op);
        if (op < 3'd2) return MUL_LAT;
        if (op < 3'd4) return W + 1;
        return 0;
    endfunction

    task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
        ex_mem_sel = 3'b011; #1 h = ex_mem_result;
        ex_mem_sel = 3'b100; #1 l = ex_mem_result;
        ex_mem_sel = 3'b000;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        op_valid = 1; op_code = op; op_a = a; op_b = b;
        step();
        op_valid = 0; op_a = $urandom; op_b = $urandom;
        lat = 0;
        while (hilo_busy && lat < 200) begin step(); lat++; end
        model_op(op, a, b);
    endtask

    task automatic test_reset();
        logic [W-1:0] h, l;
        reset = 1; alu_result = $urandom;
        step(); step();
        checks++; if (op_ready !== 1'b1 || hilo_busy !== 1'b0) begin errors++;
            $display("FAIL reset_ready: got ready=%b busy=%b want 1/0", op_ready, hilo_busy); end
        checks++; if (mem_wb_result !== '0) begin errors++;
            $display("FAIL reset_memwb: got %h want 0", mem_wb_result); end
        reset = 0;
        read_hilo(h, l);
        checks++; if (h !== '0 || l !== '0) begin errors++;
            $display("FAIL reset_hilo: got %h/%h want 0/0", h, l); end
        exp_hi = 0; exp_lo = 0;
    endtask

    task automatic test_mult();
        logic [W-1:0] h, l; int lat;
        issue(3'd0, 32'hFFFF_FFFD, 32'd5, lat);
        checks++; if (lat !== MUL_LAT) begin errors++;
            $display("FAIL mult_lat: got %0d want %0d", lat, MUL_LAT); end
        read_hilo(h, l);
        checks++; if (h !== exp_hi || l !== exp_lo) begin errors++;
            $display("FAIL mult_neg3x5: got %h/%h want %h/%h", h, l, exp_hi, exp_lo); end
    endtask

    task automatic test_div();
        logic [W-1:0] h, l; int lat;
        logic [2:0] ops [4] = '{3'd3, 3'd2, 3'd3, 3'd2};
        logic [W-1:0] as [4] = '{32'd100, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000};
        logic [W-1:0] bs [4] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], lat);
            checks++; if (lat !== W + 1) begin errors++;
                $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, W + 1); end
            read_hilo(h, l);
            checks++; if (h !== exp_hi || l !== exp_lo) begin errors++;
                $display("FAIL div[%0d]: got %h/%h want %h/%h", i, h, l, exp_hi, exp_lo); end
        end
    endtask

    task automatic test_waitrequest();
        logic [W-1:0] h, l, mw; int lat;
        op_valid = 1; op_code = 3'd3; op_a = 32'd100; op_b = 32'd7;
        step();
        op_valid = 0; lat = 0;
        repeat (9) begin step(); lat++; end
        mw = mem_wb_result;
        waitrequest = 1;
        repeat (5) begin alu_result = $urandom; step(); lat++; end
        checks++; if (mem_wb_result !== mw) begin errors++;
            $display("FAIL wait_memwb_frozen: got %h want %h", mem_wb_result, mw); end
        waitrequest = 0;
        op_valid = 1; op_code = 3'd5; op_a = 32'hABCD;
        step(); lat++;
        op_valid = 0;
        while (hilo_busy && lat < 300) begin step(); lat++; end
        model_op(3'd3, 32'd100, 32'd7);
        checks++; if (lat !== W + 1 + 5) begin errors++;
            $display("FAIL wait_lat: got %0d want %0d", lat, W + 6); end
        read_hilo(h, l);
        checks++; if (h !== exp_hi || l !== exp_lo) begin errors++;
            $display("FAIL wait_result: got %h/%h want %h/%h", h, l, exp_hi, exp_lo); end
    endtask

    task automatic test_stall_link();
        int n; logic [W-1:0] rd;
        op_valid = 1; op_code = 3'd1; op_a = $urandom; op_b = $urandom;
        model_op(3'd1, op_a, op_b);
        step();
        op_valid = 0; ex_mem_sel = 3'b100; n = 0;
        #1;
        while (hilo_busy && n < 50) begin
            checks++; if (stall_req !== 1'b1) begin errors++;
                $display("FAIL stall_busy[%0d]: got %b want 1", n, stall_req); end
            step(); n++;
        end
        checks++; if (stall_req !== 1'b0 || ex_mem_result !== exp_lo) begin errors++;
            $display("FAIL stall_release: got stall=%b lo=%h want 0/%h", stall_req, ex_mem_result, exp_lo); end
        ex_mem_sel = 3'b010; reg_pc = 32'hBFC0_0000;
        #1;
        checks++; if (ex_mem_result !== 32'hBFC0_0008) begin errors++;
            $display("FAIL link: got %h want bfc00008", ex_mem_result); end
        step();
        checks++; if (mem_wb_result !== 32'hBFC0_0008) begin errors++;
            $display("FAIL memwb_link: got %h want bfc00008", mem_wb_result); end
        rd = $urandom; mem_rdata = rd; mem_wb_sel = 1;
        #1;
        checks++; if (mem_wb_result !== rd) begin errors++;
            $display("FAIL memwb_load: got %h want %h", mem_wb_result, rd); end
        mem_wb_sel = 0; ex_mem_sel = 3'b000;
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] h, l; int lat;
        op_valid = 1; op_code = 3'd2; op_a = 32'd12345; op_b = 32'd17;
        step();
        op_valid = 0;
        repeat (9) step();
        reset = 1; step(); reset = 0;
        exp_hi = 0; exp_lo = 0;
        checks++; if (op_ready !== 1'b1 || mem_wb_result !== '0) begin errors++;
            $display("FAIL abort_state: got ready=%b memwb=%h want 1/0", op_ready, mem_wb_result); end
        read_hilo(h, l);
        checks++; if (h !== '0 || l !== '0) begin errors++;
            $display("FAIL abort_hilo: got %h/%h want 0/0", h, l); end
        issue(3'd0, 32'd6, 32'd7, lat);
        read_hilo(h, l);
        checks++; if (h !== exp_hi || l !== exp_lo) begin errors++;
            $display("FAIL abort_mult: got %h/%h want %h/%h", h, l, exp_hi, exp_lo); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] h, l, a0, a1;
        a0 = $urandom; a1 = $urandom;
        op_valid = 1; op_code = 3'd4; op_a = a0; step();
        op_code = 3'd5; op_a = a1; step();
        op_valid = 0;
        model_op(3'd4, a0, 0); model_op(3'd5, a1, 0);
        read_hilo(h, l);
        checks++; if (h !== exp_hi || l !== exp_lo) begin errors++;
            $display("FAIL mthi_mtlo: got %h/%h want %h/%h", h, l, exp_hi, exp_lo); end
    endtask

    task automatic test_random();
        logic [W-1:0] h, l, a, b; logic [2:0] op; int lat;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 5));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 4) == 0) b = 0;
            else if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 300));
            issue(op, a, b, lat);
            checks++; if (lat !== exp_lat(op)) begin errors++;
                $display("FAIL rand_lat[%0d] op%0d: got %0d want %0d", i, op, lat, exp_lat(op)); end
            read_hilo(h, l);
            checks++; if (h !== exp_hi || l !== exp_lo) begin errors++;
                $display("FAIL rand[%0d] op%0d a=%h b=%h: got %h/%h want %h/%h",
                         i, op, a, b, h, l, exp_hi, exp_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_waitrequest();
        test_stall_link();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hilo_writeback.md
Name: pipe_hilo_writeback

Overview:
Parametrised successor of the write-back/HI-LO stage.
- Owns the HI/LO register pair and an internal multi-cycle multiply/divide engine.
- Generates the EX/MEM write-back value, registers it into MEM/WB and selects the final MEM/WB write-back value.
- Issues a stall request when a HI/LO read collides with an in-flight operation.
- Sits between the EX/MEM and MEM/WB pipeline registers. All state freezes on memory waitrequest.

Parameters:
- DATA_W, 32, datapath width (HI, LO, operands, results).
- MUL_LAT, 2, multiply latency in cycles from acceptance to HI/LO update (≥1).
- LINK_OFFSET, 8, constant added to reg_pc for link write-back.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- waitrequest  input  1  memory stall; 1 freezes all state in this block
- op_valid  input  1  HI/LO operation request
- op_code  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others ignored
- op_a  input  DATA_W  rs operand (dividend / multiplicand / move source)
- op_b  input  DATA_W  rt operand (divisor / multiplier)
- op_ready  output  1  engine idle, operation can be accepted
- hilo_busy  output  1  multiply/divide in flight
- ex_mem_sel  input  3  000 ALU, 010 link, 011 HI, 100 LO; others give 0
- alu_result  input  DATA_W  EX/MEM ALU result
- reg_pc  input  DATA_W  PC of the instruction in EX/MEM
- mem_rdata  input  DATA_W  memory load data
- mem_wb_sel  input  1  1 selects load data at MEM/WB
- ex_mem_result  output  DATA_W  combinational EX/MEM write-back value
- mem_wb_result  output  DATA_W  MEM/WB write-back value
- stall_req  output  1  ex_mem_sel is HI or LO while hilo_busy=1

Behaviour:
- Reset (synchronous, active-high):
  - HI, LO and the MEM/WB register clear to 0; state goes to IDLE.
  - Reset overrides waitrequest and aborts any in-flight operation; no partial HI/LO write occurs.
- "Advance" means an edge with reset=0 and waitrequest=0. With waitrequest=1, no register, counter or state changes.
- State machine:
  - IDLE -> MUL or DIV on acceptance. Acceptance = op_valid && op_ready on an advance edge, with a valid mult/div op_code.
  - MUL -> IDLE after MUL_LAT advances.
  - DIV -> FIX after DATA_W advances; FIX -> IDLE on the next advance.
- op_ready = (state == IDLE). hilo_busy = !op_ready. op_valid while busy is ignored; it is not queued.
- MTHI/MTLO, accepted in IDLE: HI (resp. LO) <= op_a on the acceptance edge; the engine stays in IDLE.
- Multiply:
  - Operands are latched at acceptance. Full 2*DATA_W product; MULT is signed, MULTU unsigned.
  - {HI,LO} <= product on the MUL_LAT-th advance after acceptance.
- Divide:
  - Restoring divider, one quotient bit per advance, on operand magnitudes. DIV takes absolute values; DIVU uses raw operands.
  - FIX cycle applies signs: quotient is negative if the operand signs differ; remainder takes the dividend's sign. LO <= quotient, HI <= remainder.
  - Total latency is DATA_W+1 advances after acceptance.
  - Divide by zero: LO <= all ones, HI <= op_a (unchanged dividend) at the normal completion time.
  - DIV of most-negative by -1: LO <= most-negative, HI <= 0.
- ex_mem_result (combinational):
  - sel 000 -> alu_result
  - sel 010 -> reg_pc + LINK_OFFSET (mod 2^DATA_W)
  - sel 011 -> HI
  - sel 100 -> LO
  - otherwise 0
  - HI/LO reads return the current register value. A write on the same edge is visible the cycle after.
- stall_req = hilo_busy && (ex_mem_sel == 011 || ex_mem_sel == 100). Combinational; the hazard unit holds EX/MEM while it is set.
- MEM/WB register <= ex_mem_result on each advance.
- mem_wb_result = mem_wb_sel ? mem_rdata : MEM/WB register.

Test Plan:
1. Reset, then MULT op_a=0xFFFFFFFD (-3), op_b=5 -> hilo_busy high for 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; ex_mem_sel=011 returns 0xFFFFFFFF.
2. DIVU 100/7 -> op_ready low for 33 advances; then LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU in flight with waitrequest held 5 cycles mid-run -> completion delayed exactly 5 cycles; result unchanged. MTLO 0xABCD while busy -> ignored; LO keeps the divide result.
5. ex_mem_sel=100 during MULT -> stall_req=1 until the cycle after HI/LO update, then LO is returned. ex_mem_sel=010 with reg_pc=0xBFC00000 -> ex_mem_result=0xBFC00008; next advance mem_wb_result=0xBFC00008 with mem_wb_sel=0, and mem_rdata with mem_wb_sel=1.
6. Reset asserted at divide cycle 10 -> next cycle HI=LO=0, op_ready=1, mem_wb_result=0. A new MULT 6*7 then gives LO=42, HI=0.
